// File: rtl/line_mover_pkg.sv
// Shared types and sizing for the cache line transfer engine.
package line_mover_pkg;

  localparam int unsigned XLEN             = 32;
  localparam int unsigned NUM_SETS         = 4;
  localparam int unsigned SET_SIZE         = 2;
  localparam int unsigned WORDS_PER_LINE   = 8;
  localparam int unsigned WORD_SELECT_SIZE = 3;
  localparam int unsigned BYTE_SELECT_SIZE = 2;
  localparam int unsigned LINE_OFFSET_W    = WORD_SELECT_SIZE + BYTE_SELECT_SIZE;
  localparam int unsigned LINE_BASE_W      = XLEN - LINE_OFFSET_W;

  typedef enum logic [1:0] {
    MEM_OP_BYTE,
    MEM_OP_HALF,
    MEM_OP_WORD
  } memory_operation_size_e;

  typedef enum logic [2:0] {
    LM_IDLE,
    LM_EVICT,
    LM_FILL_REQ,
    LM_FILL_WAIT,
    LM_DONE
  } line_mover_state_e;

endpackage

// File: rtl/line_beat_counter.sv
// Word-within-line beat counter with synchronous clear and a last-beat flag.
module line_beat_counter
  import line_mover_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        inc,
  output logic [WORD_SELECT_SIZE-1:0] count,
  output logic                        last_c
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WORD_SELECT_SIZE'(1);
    end
  end

  assign last_c = (count == WORD_SELECT_SIZE'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/line_mover.sv
// Cache line transfer engine: optional victim write-back, then word-by-word line fill.
module line_mover
  import line_mover_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [SET_SIZE-1:0]         req_set,
  input  logic                        req_evict,
  input  logic [XLEN-1:0]             req_evict_addr,
  input  logic [XLEN-1:0]             req_fill_addr,
  output logic                        done,
  output logic                        dl_perform_write,
  output logic [SET_SIZE-1:0]         dl_set,
  output memory_operation_size_e      dl_op_size,
  output logic [WORD_SELECT_SIZE-1:0] dl_word_select,
  output logic [BYTE_SELECT_SIZE-1:0] dl_byte_select,
  output logic [XLEN-1:0]             dl_word_to_store,
  input  logic [XLEN-1:0]             dl_fetched_word,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_write,
  output logic [XLEN-1:0]             mem_req_addr,
  output logic [XLEN-1:0]             mem_req_wdata,
  input  logic                        mem_rsp_valid,
  input  logic [XLEN-1:0]             mem_rsp_rdata
);

  line_mover_state_e           state_q, state_d;
  logic [SET_SIZE-1:0]         set_q;
  logic [LINE_BASE_W-1:0]      evict_base_q, fill_base_q;
  logic [WORD_SELECT_SIZE-1:0] beat;
  logic                        beat_last_c;
  logic                        beat_clear_c, beat_inc_c;
  logic                        accept_c;
  logic                        unused_offsets;

  // Offset bits of the line addresses are meaningless to a whole-line transfer.
  assign unused_offsets = ^{req_evict_addr[LINE_OFFSET_W-1:0], req_fill_addr[LINE_OFFSET_W-1:0]};

  assign req_ready = (state_q == LM_IDLE);
  assign accept_c  = req_valid && req_ready;

  line_beat_counter u_beat (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (beat_clear_c),
    .inc     (beat_inc_c),
    .count   (beat),
    .last_c  (beat_last_c)
  );

  // Next-state and beat control.
  always_comb begin
    state_d      = state_q;
    beat_clear_c = 1'b0;
    beat_inc_c   = 1'b0;
    case (state_q)
      LM_IDLE: begin
        if (accept_c) begin
          beat_clear_c = 1'b1;
          state_d      = req_evict ? LM_EVICT : LM_FILL_REQ;
        end
      end
      LM_EVICT: begin
        if (mem_req_ready) begin
          beat_inc_c = 1'b1;
          if (beat_last_c) state_d = LM_FILL_REQ;
        end
      end
      LM_FILL_REQ: begin
        if (mem_req_ready) state_d = LM_FILL_WAIT;
      end
      LM_FILL_WAIT: begin
        if (mem_rsp_valid) begin
          beat_inc_c = 1'b1;
          state_d    = beat_last_c ? LM_DONE : LM_FILL_REQ;
        end
      end
      LM_DONE: state_d = LM_IDLE;
      default: state_d = LM_IDLE;
    endcase
  end

  // State, request latches and registered control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= LM_IDLE;
      set_q         <= '0;
      evict_base_q  <= '0;
      fill_base_q   <= '0;
      mem_req_valid <= 1'b0;
      mem_req_write <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_valid <= (state_d == LM_EVICT) || (state_d == LM_FILL_REQ);
      mem_req_write <= (state_d == LM_EVICT);
      done          <= (state_d == LM_DONE);
      if (accept_c) begin
        set_q        <= req_set;
        evict_base_q <= req_evict_addr[XLEN-1:LINE_OFFSET_W];
        fill_base_q  <= req_fill_addr[XLEN-1:LINE_OFFSET_W];
      end
    end
  end

  assign mem_req_addr  = {(state_q == LM_EVICT) ? evict_base_q : fill_base_q, beat,
                          BYTE_SELECT_SIZE'(0)};
  assign mem_req_wdata = dl_fetched_word;

  // Fill data lands in the array in the same cycle the memory returns it.
  assign dl_perform_write = (state_q == LM_FILL_WAIT) && mem_rsp_valid;
  assign dl_word_to_store = mem_rsp_rdata;
  assign dl_set           = set_q;
  assign dl_op_size       = MEM_OP_WORD;
  assign dl_word_select   = beat;
  assign dl_byte_select   = '0;

endmodule
